// File: rtl/mdio_mgmt_arbiter_if.sv
// rtl/mdio_mgmt_arbiter_if.sv - requester-side bus of the MDIO management arbiter
interface mdio_mgmt_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_wr;
    logic [5*NREQ-1:0]    req_phy;
    logic [5*NREQ-1:0]    req_reg;
    logic [16*NREQ-1:0]   req_wdata;
    logic [NREQ-1:0]      done;
    logic [15:0]          rdata;
    logic                 rd_err;
    logic                 busy;

    modport master (
        output req, req_wr, req_phy, req_reg, req_wdata,
        input  done, rdata, rd_err, busy
    );

    modport slave (
        input  req, req_wr, req_phy, req_reg, req_wdata,
        output done, rdata, rd_err, busy
    );
endinterface

// File: rtl/mdio_mgmt_arbiter.sv
// rtl/mdio_mgmt_arbiter.sv - round-robin shared Clause-22 MDIO management master
module mdio_mgmt_arbiter #(
    parameter int NREQ    = 2,
    parameter int MDC_DIV = 4,
    parameter int PRE_LEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    mdio_mgmt_arbiter_if.slave bus,
    output logic               mdc,
    output logic               mdio_o,
    output logic               mdio_oe,
    input  logic               mdio_i
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DW = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;

    typedef enum logic [3:0] {
        IDLE, PRE, ST, OP, PHYAD, REGAD, TA, DATA, DONE
    } state_t;

    state_t          state, nxt_state;
    logic [IW-1:0]   ptr, gnt;
    logic            op_wr;
    logic [31:0]     tx_sr;     // ST..DATA bits, MSB goes out next
    logic [15:0]     rx_sr;
    logic            err_flag;
    logic [4:0]      fcnt, nxt_fcnt;  // bits left in the current field after this one
    logic [DW-1:0]   div_cnt;
    logic            launch;    // first preamble bit goes out the clk after grant

    logic            found;
    logic [IW-1:0]   gidx, cand;
    logic            g_wr;
    logic [4:0]      g_phy, g_reg;
    logic [15:0]     g_wd;

    // Round-robin search upward from ptr+1 and pick out the winner's request fields
    always_comb begin
        found = 1'b0;
        gidx  = ptr;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                gidx  = cand;
            end
        end
        g_wr  = bus.req_wr[gidx];
        g_phy = bus.req_phy[5*gidx +: 5];
        g_reg = bus.req_reg[5*gidx +: 5];
        g_wd  = bus.req_wdata[16*gidx +: 16];
    end

    // Field sequencing: which field the next bit belongs to
    always_comb begin
        nxt_state = state;
        nxt_fcnt  = fcnt - 5'd1;
        if (fcnt == 5'd0) begin
            case (state)
                PRE:     begin nxt_state = ST;    nxt_fcnt = 5'd1;  end
                ST:      begin nxt_state = OP;    nxt_fcnt = 5'd1;  end
                OP:      begin nxt_state = PHYAD; nxt_fcnt = 5'd4;  end
                PHYAD:   begin nxt_state = REGAD; nxt_fcnt = 5'd4;  end
                REGAD:   begin nxt_state = TA;    nxt_fcnt = 5'd1;  end
                TA:      begin nxt_state = DATA;  nxt_fcnt = 5'd15; end
                DATA:    begin nxt_state = DONE;  nxt_fcnt = 5'd0;  end
                default: begin nxt_state = state; nxt_fcnt = 5'd0;  end
            endcase
        end
    end

    // Grant, MDC divider, frame serializer and read capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= IW'(NREQ - 1);
            gnt        <= '0;
            op_wr      <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            err_flag   <= 1'b0;
            fcnt       <= '0;
            div_cnt    <= '0;
            launch     <= 1'b0;
            mdc        <= 1'b0;
            mdio_o     <= 1'b1;
            mdio_oe    <= 1'b0;
            bus.done   <= '0;
            bus.rdata  <= '0;
            bus.rd_err <= 1'b0;
            bus.busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        ptr      <= gidx;
                        gnt      <= gidx;
                        op_wr    <= g_wr;
                        // Read frames park mdio_o high while the PHY owns the line
                        tx_sr    <= g_wr ? {4'b0101, g_phy, g_reg, 2'b10, g_wd}
                                         : {4'b0110, g_phy, g_reg, 18'h3FFFF};
                        err_flag <= 1'b0;
                        fcnt     <= 5'(PRE_LEN - 1);
                        launch   <= 1'b1;
                        bus.busy <= 1'b1;
                        state    <= PRE;
                    end
                end
                DONE: begin
                    bus.done <= '0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    if (launch) begin
                        launch  <= 1'b0;
                        div_cnt <= '0;
                        mdio_o  <= 1'b1;
                        mdio_oe <= 1'b1;
                    end else if (div_cnt == DW'(MDC_DIV - 1)) begin
                        div_cnt <= '0;
                        mdc     <= ~mdc;
                        if (!mdc) begin
                            // Rising MDC: sample the PHY only where it owns the line
                            if (!op_wr && state == TA && fcnt == 5'd0)
                                err_flag <= mdio_i;
                            if (!op_wr && state == DATA)
                                rx_sr <= {rx_sr[14:0], mdio_i};
                        end else begin
                            // Falling MDC: current bit ends, launch the next one
                            state <= nxt_state;
                            fcnt  <= nxt_fcnt;
                            if (nxt_state == DONE) begin
                                mdio_o  <= 1'b1;
                                mdio_oe <= 1'b0;
                                for (int i = 0; i < NREQ; i++)
                                    bus.done[i] <= (gnt == IW'(i));
                                if (op_wr) begin
                                    bus.rd_err <= 1'b0;
                                end else begin
                                    bus.rdata  <= rx_sr;
                                    bus.rd_err <= err_flag;
                                end
                            end else if (nxt_state == PRE) begin
                                mdio_o  <= 1'b1;
                                mdio_oe <= 1'b1;
                            end else begin
                                mdio_o  <= tx_sr[31];
                                tx_sr   <= {tx_sr[30:0], 1'b1};
                                mdio_oe <= op_wr || !(nxt_state == TA || nxt_state == DATA);
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mdio_mgmt_arbiter.sv
// tb/tb_mdio_mgmt_arbiter.sv - scoreboard bench for mdio_mgmt_arbiter
module tb_mdio_mgmt_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic mdc, mdio_o, mdio_oe, mdio_i;

    mdio_mgmt_arbiter_if #(.NREQ(2)) bus();

    mdio_mgmt_arbiter #(.NREQ(2), .MDC_DIV(2), .PRE_LEN(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .mdc     (mdc),
        .mdio_o  (mdio_o),
        .mdio_oe (mdio_oe),
        .mdio_i  (mdio_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        bit          wr;
        logic [31:0] hdr;
        logic [15:0] rdata;
        bit          err;
    } exp_t;

    exp_t sb[$];
    int   check_cnt = 0;
    int   pass_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // PHY model: TA second bit driven 0 and data MSB first when present, else pulled high
    bit          phy_on = 1'b0;
    logic [15:0] phy_data = 16'h0;
    int          bcnt = 0;
    always_comb begin
        mdio_i = 1'b1;
        if (phy_on) begin
            if (bcnt == 47)
                mdio_i = 1'b0;
            else if (bcnt >= 48 && bcnt <= 63)
                mdio_i = phy_data[63 - bcnt];
        end
    end

    // Monitor: capture bits at MDC rise, pop and compare on every done pulse
    int          first_cyc = -1, last_rise = -1, per_bad = 0, badb;
    logic        busy_q = 1'b0, mdc_q = 1'b0, eo, eoe;
    logic [1:0]  done_q = 2'b00;
    logic [63:0] o_bits = '0, oe_bits = '0;
    exp_t        e;
    always @(negedge clk) begin
        if (bus.busy && !busy_q) begin
            bcnt = 0; first_cyc = -1; last_rise = -1; per_bad = 0;
        end
        if (bus.busy && mdio_oe && first_cyc < 0) first_cyc = cyc;
        if (mdc && !mdc_q) begin
            if (last_rise >= 0 && cyc - last_rise != 4) per_bad++;
            last_rise = cyc;
            if (bcnt < 64) begin
                o_bits[bcnt]  = mdio_o;
                oe_bits[bcnt] = mdio_oe;
            end
            bcnt++;
        end
        if (done_q != 2'b00) chk("done_width", 32'(bus.done), 32'd0);
        if (bus.done != 2'b00) begin
            if (sb.size() == 0) begin
                check_cnt++;
                $display("FAIL unexpected_done: got done=%b expected none", bus.done);
            end else begin
                e = sb.pop_front();
                chk("done_vec", 32'(bus.done), 32'd1 << e.idx);
                chk("rdata", 32'(bus.rdata), 32'(e.rdata));
                chk("rd_err", 32'(bus.rd_err), 32'(e.err));
                chk("bit_count", bcnt, 64);
                chk("done_latency", cyc - first_cyc, 256);
                chk("bit_period_errs", per_bad, 0);
                badb = 64;
                for (int b = 0; b < 64; b++) begin
                    if (b < 32) begin
                        eo = 1'b1; eoe = 1'b1;
                    end else if (e.wr || b < 46) begin
                        eo = e.hdr[63 - b]; eoe = 1'b1;
                    end else begin
                        eo = 1'b0; eoe = 1'b0;
                    end
                    if (badb == 64 && (oe_bits[b] !== eoe || (eoe && o_bits[b] !== eo)))
                        badb = b;
                end
                chk("frame_first_bad_bit", badb, 64);
            end
        end
        busy_q = bus.busy;
        mdc_q  = mdc;
        done_q = bus.done;
    end

    task automatic start_frame(input int idx, input bit wr, input logic [4:0] phy,
                               input logic [4:0] rg, input logic [15:0] wd,
                               input logic [31:0] hdr, input logic [15:0] rd, input bit err);
        exp_t x;
        bus.req_wr[idx]             = wr;
        bus.req_phy[5*idx +: 5]     = phy;
        bus.req_reg[5*idx +: 5]     = rg;
        bus.req_wdata[16*idx +: 16] = wd;
        x.idx = idx; x.wr = wr; x.hdr = hdr; x.rdata = rd; x.err = err;
        sb.push_back(x);
        bus.req[idx] = 1'b1;
    endtask

    task automatic wait_done(input int idx, input bit drop, output int dcyc);
        bit seen = 1'b0;
        dcyc = cyc;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (bus.done[idx]) begin seen = 1'b1; break; end
        end
        if (!seen) begin
            check_cnt++;
            $display("FAIL timeout_done%0d: got no done pulse, expected one", idx);
        end
        dcyc = cyc;
        if (drop) bus.req[idx] = 1'b0;
    endtask

    task automatic wait_bits(input int lo, input int hi);
        bit seen = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (bus.busy && bcnt >= lo && bcnt <= hi) begin seen = 1'b1; break; end
        end
        if (!seen) begin
            check_cnt++;
            $display("FAIL timeout_bits: got no bit index in %0d..%0d", lo, hi);
        end
    endtask

    task automatic check_gap(input int dcyc);
        bit seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.busy) begin seen = 1'b1; break; end
        end
        if (seen) chk("frame_gap", cyc - dcyc, 2);
        else begin
            check_cnt++;
            $display("FAIL timeout_gap: got no new grant, expected one 2 clk after done");
        end
    endtask

    int dcyc;
    initial begin
        rst = 1'b1;
        bus.req = '0; bus.req_wr = '0; bus.req_phy = '0; bus.req_reg = '0; bus.req_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_rdata", 32'(bus.rdata), 0);
        chk("rst_rd_err", 32'(bus.rd_err), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_mdc", 32'(mdc), 0);
        chk("rst_mdio_o", 32'(mdio_o), 1);
        chk("rst_mdio_oe", 32'(mdio_oe), 0);

        // Write on requester 0
        start_frame(0, 1, 5'h10, 5'h00, 16'h8140, 32'h5802_8140, 16'h0000, 0);
        wait_done(0, 1, dcyc);

        // Read on requester 1 with PHY present
        phy_on = 1'b1; phy_data = 16'h796D;
        start_frame(1, 0, 5'h10, 5'h01, 16'h0000, 32'h6804_0000, 16'h796D, 0);
        wait_done(1, 1, dcyc);

        // Write on requester 0, request dropped during DATA, then a read on requester 0
        start_frame(0, 1, 5'h05, 5'h11, 16'h3C0F, 32'h52C6_3C0F, 16'h796D, 0);
        wait_bits(50, 60);
        chk("rdata_hold_mid_write", 32'(bus.rdata), 32'h796D);
        bus.req[0] = 1'b0;
        wait_done(0, 0, dcyc);
        phy_data = 16'h1234;
        start_frame(0, 0, 5'h10, 5'h01, 16'h0000, 32'h6804_0000, 16'h1234, 0);
        wait_done(0, 1, dcyc);

        // Read with PHY absent
        phy_on = 1'b0;
        start_frame(1, 0, 5'h01, 5'h02, 16'h0000, 32'h6088_0000, 16'hFFFF, 1);
        wait_done(1, 1, dcyc);

        // Reset during PHYAD abandons the frame
        start_frame(0, 1, 5'h10, 5'h00, 16'h8140, 32'h5802_8140, 16'hFFFF, 0);
        wait_bits(38, 40);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_mdc", 32'(mdc), 0);
        chk("rstmid_mdio_oe", 32'(mdio_oe), 0);
        chk("rstmid_mdio_o", 32'(mdio_o), 1);
        chk("rstmid_busy", 32'(bus.busy), 0);
        chk("rstmid_done", 32'(bus.done), 0);
        chk("rstmid_rdata", 32'(bus.rdata), 0);
        void'(sb.pop_back());
        bus.req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        start_frame(0, 1, 5'h10, 5'h00, 16'h8140, 32'h5802_8140, 16'h0000, 0);
        wait_done(0, 1, dcyc);

        // Both requesting from reset: grants rotate 0,1,0,1
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_frame(0, 1, 5'h03, 5'h04, 16'hA5C3, 32'h5192_A5C3, 16'h0000, 0);
        start_frame(1, 1, 5'h1F, 5'h1E, 16'h0001, 32'h5FFA_0001, 16'h0000, 0);
        start_frame(0, 1, 5'h03, 5'h04, 16'hA5C3, 32'h5192_A5C3, 16'h0000, 0);
        start_frame(1, 1, 5'h1F, 5'h1E, 16'h0001, 32'h5FFA_0001, 16'h0000, 0);
        for (int f = 0; f < 4; f++) begin
            wait_done(f % 2, f >= 2, dcyc);
            if (f < 3) check_gap(dcyc);
        end

        repeat (20) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, expected finish before 1 ms");
        $display("%0d/%0d checks passed", pass_cnt, check_cnt + 1);
        $fatal(1);
    end
endmodule
